// File: rtl/tx_toe_pkt_gen_if.sv
// Command and TOE-side signal bundle for tx_toe_pkt_gen.
// The generator connects through the slave modport and the driver through master.
interface tx_toe_pkt_gen_if #(
    parameter int unsigned N_CHAN = 2,
    parameter int unsigned CHAN_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CHAN_W-1:0] cmd_chan;
    logic [7:0]        cmd_type;
    logic [15:0]       cmd_row;
    logic [7:0]        cmd_pic;
    logic              tx;
    logic [7:0]        tx_data;
    logic [CHAN_W-1:0] tx_chan;
    logic [N_CHAN-1:0] tx_full;
    logic              flash_done;
    logic              busy;
    logic              drop_err;

    modport master (
        output cmd_valid, cmd_chan, cmd_type, cmd_row, cmd_pic, tx_full, flash_done,
        input  cmd_ready, tx, tx_data, tx_chan, busy, drop_err
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_type, cmd_row, cmd_pic, tx_full, flash_done,
        output cmd_ready, tx, tx_data, tx_chan, busy, drop_err
    );
endinterface

// File: rtl/tx_toe_pkt_gen.sv
// Buffered N-channel TOE packet generator: each queued row command becomes a 9-byte packet
// carrying a per-channel sequence number and a ones'-complement checksum.
module tx_toe_pkt_gen #(
    parameter int unsigned N_CHAN     = 2,
    parameter int unsigned CHAN_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] MAGIC      = 16'hA55A
) (
    input logic             clk,
    input logic             rst_n,
    tx_toe_pkt_gen_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = CHAN_W + 32;

    typedef enum logic [1:0] {StIdle, StLoad, StCsum, StSend} state_e;
    state_e state_q, state_d;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cmd_ready_q;
    logic              push, pop;

    logic [EW-1:0]     head_q;
    logic [CHAN_W-1:0] head_chan;
    logic              head_ok;
    logic [7:0]        seq_q [N_CHAN];
    logic [7:0]        seq_sel;

    logic [7:0]        type_q, pic_q, seq_byte_q, tx_data_q, byte_nxt;
    logic [15:0]       row_q, cks_q, cks_d;
    logic [3:0]        idx_q;
    logic [CHAN_W-1:0] tx_chan_q;
    logic              chan_full, load, drop, adv;
    logic [17:0]       sum;
    logic [16:0]       fold1;
    logic [15:0]       fold2;

    // Entry layout: {chan, type, row, pic}
    assign head_chan = head_q[EW-1:32];
    assign head_ok   = 32'(head_chan) < N_CHAN;
    assign push      = bus.cmd_valid && cmd_ready_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            head_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cmd_ready_q <= (cnt_d != CW'(FIFO_DEPTH));
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                head_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_chan, bus.cmd_type, bus.cmd_row, bus.cmd_pic};
    end

    always_comb begin
        chan_full = 1'b0;
        seq_sel   = 8'h00;
        for (int i = 0; i < N_CHAN; i++) begin
            if (tx_chan_q == CHAN_W'(i)) chan_full = bus.tx_full[i];
            if (head_chan == CHAN_W'(i)) seq_sel = seq_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            StIdle: begin
                if ((cnt_q != '0) && bus.flash_done) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (head_ok) begin
                    load    = 1'b1;
                    state_d = StCsum;
                end else begin
                    drop    = 1'b1;
                    state_d = StIdle;
                end
            end
            StCsum: state_d = StSend;
            StSend: begin
                adv = !chan_full;
                if (adv && (idx_q == 4'd8)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte that follows the one currently on tx_data
    always_comb begin
        byte_nxt = 8'h00;
        case (idx_q)
            4'd0:    byte_nxt = MAGIC[7:0];
            4'd1:    byte_nxt = type_q;
            4'd2:    byte_nxt = row_q[15:8];
            4'd3:    byte_nxt = row_q[7:0];
            4'd4:    byte_nxt = pic_q;
            4'd5:    byte_nxt = seq_byte_q;
            4'd6:    byte_nxt = cks_q[15:8];
            4'd7:    byte_nxt = cks_q[7:0];
            default: byte_nxt = 8'h00;
        endcase
    end

    always_comb begin
        sum   = {2'b00, MAGIC} + {2'b00, type_q, row_q[15:8]} + {2'b00, row_q[7:0], pic_q}
              + {2'b00, seq_byte_q, 8'h00};
        fold1 = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        cks_d = ~fold2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            type_q     <= '0;
            row_q      <= '0;
            pic_q      <= '0;
            seq_byte_q <= '0;
            cks_q      <= '0;
            idx_q      <= '0;
            tx_chan_q  <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                type_q     <= head_q[31:24];
                row_q      <= head_q[23:8];
                pic_q      <= head_q[7:0];
                seq_byte_q <= seq_sel;
                tx_chan_q  <= head_chan;
                tx_data_q  <= MAGIC[15:8];
            end
            if (state_q == StCsum) begin
                cks_q <= cks_d;
                idx_q <= '0;
            end
            if (adv && (idx_q != 4'd8)) begin
                idx_q     <= idx_q + 4'd1;
                tx_data_q <= byte_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHAN; i++) seq_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (head_chan == CHAN_W'(i)) seq_q[i] <= seq_q[i] + 8'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx        = adv;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_chan   = tx_chan_q;
    assign bus.busy      = (state_q != StIdle) || (cnt_q != '0);
    assign bus.drop_err  = drop;
endmodule

// File: tb/tb_tx_toe_pkt_gen.sv
// Directed self-checking bench for tx_toe_pkt_gen; all inputs change and outputs are
// sampled on the falling clock edge.
module tb_tx_toe_pkt_gen;
    localparam int unsigned N_CHAN     = 2;
    localparam int unsigned CHAN_W     = 3;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [8:0][7:0] pkt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_toe_pkt_gen_if #(.N_CHAN(N_CHAN), .CHAN_W(CHAN_W)) bus ();

    tx_toe_pkt_gen #(
        .N_CHAN     (N_CHAN),
        .CHAN_W     (CHAN_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAGIC      (16'hA55A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_chan   = '0;
        bus.cmd_type   = '0;
        bus.cmd_row    = '0;
        bus.cmd_pic    = '0;
        bus.tx_full    = '0;
        bus.flash_done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns on the falling edge right after the accepting rising edge.
    task automatic send_cmd(input logic [CHAN_W-1:0] ch, input logic [7:0] ty,
                            input logic [15:0] row, input logic [7:0] pic, output bit ok);
        int k = 0;
        bus.cmd_chan  = ch;
        bus.cmd_type  = ty;
        bus.cmd_row   = row;
        bus.cmd_pic   = pic;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.cmd_ready === 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic collect_pkt(output pkt_t d, output logic [CHAN_W-1:0] ch, output int lat,
                               output int first, output int last, output bit ok);
        int k = 0;
        int n = 0;
        int g = 0;
        d = '0; ch = '0; lat = -1; first = 0; last = 0; ok = 1'b0;
        while (bus.tx !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (bus.tx !== 1'b1) return;
        lat   = k;
        first = cyc;
        while (n < 9 && g < 300) begin
            if (bus.tx === 1'b1) begin
                d[n] = bus.tx_data;
                ch   = bus.tx_chan;
                last = cyc;
                n++;
            end
            @(negedge clk);
            g++;
        end
        ok = (n == 9);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.tx_full = '0; bus.flash_done = 1'b1;
        @(negedge clk);
        n_total++; if (bus.tx !== 1'b0) $display("FAIL reset_tx got %b exp 0", bus.tx);
        else n_pass++;
        n_total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", bus.tx_data);
        else n_pass++;
        n_total++; if (bus.tx_chan !== 3'd0) $display("FAIL reset_tx_chan got %0d exp 0", bus.tx_chan);
        else n_pass++;
        n_total++; if (bus.drop_err !== 1'b0) $display("FAIL reset_drop got %b exp 0", bus.drop_err);
        else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy);
        else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.cmd_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pkt_t d, exp_b;
        logic [CHAN_W-1:0] ch;
        int lat, first, last;
        bit ok, acc;
        exp_b = {8'h9F, 8'h56, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h5A, 8'hA5};
        do_reset();
        send_cmd(3'd1, 8'h01, 16'h0203, 8'h04, acc);
        collect_pkt(d, ch, lat, first, last, ok);
        n_total++; if (!(acc && ok)) $display("FAIL basic_done got acc=%b ok=%b exp 1 1", acc, ok);
        else n_pass++;
        // Accept edge E: samples after E show IDLE, LOAD, CSUM, then SEND on the third.
        n_total++; if (lat != 3) $display("FAIL basic_latency got %0d exp 3", lat);
        else n_pass++;
        n_total++; if (ch !== 3'd1) $display("FAIL basic_chan got %0d exp 1", ch);
        else n_pass++;
        n_total++; if (last - first != 8) $display("FAIL basic_span got %0d exp 8", last - first);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (d[i] !== exp_b[i]) $display("FAIL basic_byte%0d got %h exp %h", i, d[i], exp_b[i]);
            else n_pass++;
        end
    endtask

    task automatic test_carry_fold();
        pkt_t d, exp_c;
        logic [CHAN_W-1:0] ch;
        int lat, first, last;
        bit ok, acc;
        exp_c = {8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'hA5};
        do_reset();
        send_cmd(3'd0, 8'hFF, 16'hFFFF, 8'hFF, acc);
        collect_pkt(d, ch, lat, first, last, ok);
        n_total++; if (!(acc && ok)) $display("FAIL carry_done got acc=%b ok=%b exp 1 1", acc, ok);
        else n_pass++;
        n_total++; if (ch !== 3'd0) $display("FAIL carry_chan got %0d exp 0", ch);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (d[i] !== exp_c[i]) $display("FAIL carry_byte%0d got %h exp %h", i, d[i], exp_c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        pkt_t d, exp_b;
        int k = 0, n = 0, guard = 0, stall_cnt = 0, held_bad = 0, idle = 0, dup = 0;
        bit acc;
        exp_b = {8'h9F, 8'h56, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h5A, 8'hA5};
        d = '0;
        do_reset();
        bus.tx_full = 2'b01;  // other channel full throughout: must not stall channel 1
        send_cmd(3'd1, 8'h01, 16'h0203, 8'h04, acc);
        while (bus.tx !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        while (n < 9 && guard < 100) begin
            if (n == 3 && stall_cnt < 5) begin
                bus.tx_full = 2'b11;
                #1;
                if (bus.tx !== 1'b0 || bus.tx_data !== 8'h02) held_bad++;
                stall_cnt++;
            end else begin
                bus.tx_full = 2'b01;
                #1;
                if (bus.tx === 1'b1) begin
                    d[n] = bus.tx_data;
                    n++;
                end else idle++;
            end
            @(negedge clk);
            guard++;
        end
        for (int j = 0; j < 6; j++) begin
            if (bus.tx === 1'b1) dup++;
            @(negedge clk);
        end
        bus.tx_full = '0;
        n_total++; if (n != 9) $display("FAIL bp_count got %0d exp 9 (acc=%b)", n, acc);
        else n_pass++;
        n_total++; if (stall_cnt != 5) $display("FAIL bp_stalls got %0d exp 5", stall_cnt);
        else n_pass++;
        n_total++; if (held_bad != 0) $display("FAIL bp_hold got %0d bad cycles exp 0", held_bad);
        else n_pass++;
        n_total++; if (idle != 0) $display("FAIL bp_other_chan got %0d idle exp 0", idle);
        else n_pass++;
        n_total++; if (dup != 0) $display("FAIL bp_extra got %0d bytes exp 0", dup);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (d[i] !== exp_b[i]) $display("FAIL bp_byte%0d got %h exp %h", i, d[i], exp_b[i]);
            else n_pass++;
        end
    endtask

    task automatic test_queue_gate();
        pkt_t pk [5];
        logic [CHAN_W-1:0] chs [5];
        int firsts [5];
        int lasts [5];
        bit oks [5];
        int lat, acc_cnt = 0, tx_seen = 0, ready_seen = 0, k = 0;
        bit acc, acc5 = 1'b0;
        do_reset();
        bus.flash_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(CHAN_W'(i % 2), 8'(i + 1), 16'(16'h0100 + i), 8'(8'h10 + i), acc);
            if (acc) acc_cnt++;
        end
        n_total++; if (acc_cnt != 4) $display("FAIL qg_accepted got %0d exp 4", acc_cnt);
        else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL qg_full_ready got %b exp 0", bus.cmd_ready);
        else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL qg_busy got %b exp 1", bus.busy);
        else n_pass++;
        bus.cmd_chan = 3'd0; bus.cmd_type = 8'd5; bus.cmd_row = 16'h0104; bus.cmd_pic = 8'h14;
        bus.cmd_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (bus.tx === 1'b1) tx_seen++;
            if (bus.cmd_ready === 1'b1) ready_seen++;
            @(negedge clk);
        end
        n_total++; if (tx_seen != 0) $display("FAIL qg_gate_tx got %0d exp 0", tx_seen);
        else n_pass++;
        n_total++; if (ready_seen != 0) $display("FAIL qg_held got %0d exp 0", ready_seen);
        else n_pass++;
        bus.flash_done = 1'b1;
        fork
            begin
                while (bus.cmd_ready !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                acc5 = (bus.cmd_ready === 1'b1);
                @(negedge clk);
                bus.cmd_valid = 1'b0;
            end
            begin
                for (int p = 0; p < 5; p++) collect_pkt(pk[p], chs[p], lat, firsts[p], lasts[p], oks[p]);
            end
        join
        n_total++; if (acc5 !== 1'b1) $display("FAIL qg_fifth_accept got %b exp 1", acc5);
        else n_pass++;
        for (int p = 0; p < 5; p++) begin
            n_total++;
            if (!oks[p] || chs[p] !== CHAN_W'(p % 2) || pk[p][2] !== 8'(p + 1) || pk[p][6] !== 8'(p / 2))
                $display("FAIL qg_pkt%0d got ok=%b chan=%0d type=%h seq=%h exp 1 %0d %h %h",
                         p, oks[p], chs[p], pk[p][2], pk[p][6], p % 2, 8'(p + 1), 8'(p / 2));
            else n_pass++;
        end
        for (int p = 0; p < 4; p++) begin
            n_total++;
            if (firsts[p + 1] - lasts[p] != 4)
                $display("FAIL qg_gap%0d got %0d exp 3", p, firsts[p + 1] - lasts[p] - 1);
            else n_pass++;
        end
    endtask

    task automatic test_seq_wrap();
        pkt_t d;
        logic [CHAN_W-1:0] ch;
        int lat, first, last;
        bit ok, acc;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            send_cmd(3'd0, 8'h22, 16'(i), 8'h33, acc);
            collect_pkt(d, ch, lat, first, last, ok);
            n_total++;
            if (!(acc && ok) || d[6] !== 8'(i) || ch !== 3'd0)
                $display("FAIL seq_ch0_%0d got seq=%h chan=%0d ok=%b exp %h 0 1",
                         i, d[6], ch, ok, 8'(i));
            else n_pass++;
        end
        send_cmd(3'd1, 8'h22, 16'h0000, 8'h33, acc);
        collect_pkt(d, ch, lat, first, last, ok);
        n_total++;
        if (!(acc && ok) || d[6] !== 8'h00 || ch !== 3'd1)
            $display("FAIL seq_ch1 got seq=%h chan=%0d ok=%b exp 00 1 1", d[6], ch, ok);
        else n_pass++;
    endtask

    task automatic test_invalid_chan();
        pkt_t d;
        logic [CHAN_W-1:0] ch;
        int lat, first, last, drop_cnt = 0, drop_pos = -1, tx_cnt = 0;
        bit ok, acc;
        do_reset();
        send_cmd(3'd2, 8'h01, 16'h0203, 8'h04, acc);
        for (int j = 0; j < 10; j++) begin
            if (bus.drop_err === 1'b1) begin
                drop_cnt++;
                if (drop_pos < 0) drop_pos = j;
            end
            if (bus.tx === 1'b1) tx_cnt++;
            @(negedge clk);
        end
        n_total++; if (drop_cnt != 1) $display("FAIL inv_drop_cnt got %0d exp 1", drop_cnt);
        else n_pass++;
        n_total++; if (drop_pos != 1) $display("FAIL inv_drop_pos got %0d exp 1", drop_pos);
        else n_pass++;
        n_total++; if (tx_cnt != 0) $display("FAIL inv_tx got %0d exp 0", tx_cnt);
        else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL inv_busy got %b exp 0", bus.busy);
        else n_pass++;
        send_cmd(3'd0, 8'h01, 16'h0203, 8'h04, acc);
        collect_pkt(d, ch, lat, first, last, ok);
        n_total++;
        if (!(acc && ok) || d[6] !== 8'h00) $display("FAIL inv_seq got %h ok=%b exp 00 1", d[6], ok);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int k = 0, n = 0, tx_after = 0;
        bit fired = 1'b0, acc1, acc2;
        logic [7:0] b4 = 8'h00;
        do_reset();
        send_cmd(3'd1, 8'h01, 16'h0203, 8'h04, acc1);
        send_cmd(3'd0, 8'h07, 16'h0809, 8'h0A, acc2);
        while (!fired && k < 100) begin
            if (bus.tx === 1'b1) begin
                if (n == 4) begin
                    b4 = bus.tx_data;
                    fired = 1'b1;
                end else n++;
            end
            if (!fired) @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        #1;
        n_total++; if (!fired || b4 !== 8'h03) $display("FAIL rmid_byte4 got %h exp 03", b4);
        else n_pass++;
        n_total++; if (bus.tx !== 1'b0) $display("FAIL rmid_tx got %b exp 0", bus.tx);
        else n_pass++;
        n_total++; if (bus.tx_data !== 8'h00) $display("FAIL rmid_tx_data got %h exp 00", bus.tx_data);
        else n_pass++;
        n_total++; if (bus.tx_chan !== 3'd0) $display("FAIL rmid_tx_chan got %0d exp 0", bus.tx_chan);
        else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", bus.busy);
        else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", bus.cmd_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus.tx === 1'b1) tx_after++;
        end
        n_total++;
        if (tx_after != 0) $display("FAIL rmid_queue_lost got %0d bytes exp 0 (acc=%b%b)",
                                    tx_after, acc1, acc2);
        else n_pass++;
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_chan   = '0;
        bus.cmd_type   = '0;
        bus.cmd_row    = '0;
        bus.cmd_pic    = '0;
        bus.tx_full    = '0;
        bus.flash_done = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry_fold();
        test_backpressure();
        test_queue_gate();
        test_seq_wrap();
        test_invalid_chan();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion (%0d/%0d so far)", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/tx_toe_pkt_gen.md
# tx_toe_pkt_gen

Parametrised packet transmitter toward the TOE. It accepts image-row commands (type, row, picture, destination channel) into a small command FIFO. For each command it builds a fixed-format 9-byte packet with a per-channel sequence number and a 16-bit ones'-complement checksum. It streams the packet byte-by-byte to the TOE write port, honouring per-channel full flags and the flash-done gate. It replaces the single-command, ROM-template transmitter path with an N-channel, buffered, self-contained generator.

## Interface
- N_CHAN, 2: number of TOE channels served; 1..2^CHAN_W.
- CHAN_W, 3: width of channel index.
- FIFO_DEPTH, 4: command FIFO depth; power of two, >=2.
- MAGIC, 16'hA55A: packet header word.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; command accepted when cmd_valid&&cmd_ready.
- cmd_chan  in  CHAN_W  destination channel.
- cmd_type  in  8  packet type.
- cmd_row  in  16  row number.
- cmd_pic  in  8  picture index.
- tx  out  1  byte strobe to TOE, one byte per high cycle.
- tx_data  out  8  packet byte.
- tx_chan  out  CHAN_W  channel of current packet.
- tx_full  in  N_CHAN  per-channel TOE full; bit i stalls channel i.
- flash_done  in  1  high = new packets may start.
- busy  out  1  FSM not in IDLE or FIFO non-empty.
- drop_err  out  1  one-cycle pulse when a command with cmd_chan>=N_CHAN is discarded.

## Operation
- Packet bytes, in order: MAGIC[15:8], MAGIC[7:0], type, row[15:8], row[7:0], pic, seq, cks[15:8], cks[7:0].
- seq: per-channel 8-bit counter. It is used and then incremented when that channel's packet is loaded in LOAD, and wraps 0xFF->0x00. Counters are independent per channel.
- Checksum words: {MAGIC}, {type,row[15:8]}, {row[7:0],pic}, {seq,8'h00}.
  - Form the sum at 18+ bits.
  - Fold the carry into the low 16 bits twice.
  - cks = ~folded.
- FSM states: IDLE, LOAD, CSUM, SEND.
  - IDLE: if FIFO non-empty and flash_done=1, pop the head and go to LOAD. Otherwise stay.
  - LOAD: if the popped chan>=N_CHAN, pulse drop_err, do not touch any seq, return to IDLE. Otherwise latch fields and seq[chan], increment seq[chan], go to CSUM.
  - CSUM: compute and register cks; byte index=0; go to SEND.
  - SEND: tx = ~tx_full[tx_chan]. Byte index advances only on cycles with tx=1. After byte 8 is emitted, go to IDLE.
- tx_chan and tx_data are registered and change only at LOAD or on a byte advance. tx is combinational from state and tx_full.
- FIFO push and pop in the same cycle are allowed when full or empty-with-pending-write rules permit:
  - When full, push is blocked by cmd_ready=0, even if a pop occurs in the same cycle (registered cmd_ready).
  - A pop on empty never occurs.
- flash_done falling mid-packet: the current packet completes; no new packet starts until flash_done=1.
- tx_full asserted mid-packet: hold the current byte on tx_data with tx=0. The packet is never abandoned.

## Timing
- Reset values:
  - tx=0, tx_data=0, tx_chan=0, drop_err=0, busy=0.
  - cmd_ready=1, FIFO empty, all seq=0, FSM=IDLE.
- Reset mid-packet aborts immediately. No further bytes are emitted, and queued commands are lost.
- Latency: command accepted at edge E -> IDLE sees non-empty in cycle E+1 -> LOAD E+2 -> CSUM E+3 -> first tx=1 in cycle E+4 (unstalled, flash_done=1).
- Unstalled packet: 9 consecutive tx cycles.
- Back-to-back packets: 3-cycle gap (IDLE, LOAD, CSUM) between the last byte and the next first byte.
- cmd_ready updates the cycle after the FIFO count changes.
- drop_err is high for exactly the LOAD cycle.

## Test plan
- Basic packet: MAGIC=A55A; cmd chan=1, type=0x01, row=0x0203, pic=0x04; tx_full=0. Expect tx_chan=1 and bytes A5 5A 01 02 03 04 00 56 9F, with the first byte 4 cycles after acceptance.
- Carry fold: type=0xFF, row=0xFFFF, pic=0xFF, seq=0. Expect cks=0x5AA5.
- Backpressure: assert tx_full[1] for 5 cycles after byte 2. Expect tx=0 for those cycles, byte 3 held on tx_data, all 9 bytes delivered, none duplicated. Asserting tx_full[0] during the same period has no effect on channel 1.
- Queue/gate:
  - With flash_done=0, push 5 commands. Expect cmd_ready=0 after the 4th; the 5th is held; no tx.
  - Raise flash_done. Expect 4 packets with 3-cycle gaps, then the 5th is accepted and sent.
- Sequence wrap and isolation: send 257 packets on ch0 and 1 on ch1. Expect ch0 seq bytes 00..FF then 00, and ch1 seq=00.
- Invalid channel / reset: cmd_chan=2 with N_CHAN=2 -> one drop_err pulse, no tx, seq unchanged. Asserting rst_n=0 during byte 4 -> tx=0 immediately; all outputs take reset values.
